// File: rtl/flash_fetch_pkg.sv
// ============================================================================
// Module      : flash_fetch_pkg
// Description : Shared types and constants for the NOR-flash instruction
//               fetch controller: FSM state encoding, default timing
//               parameters, flash bus widths and the request legality check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_fetch_pkg;

    localparam int unsigned DEF_WAIT_CYCLES = 8;
    localparam int unsigned DEF_RST_CYCLES  = 16;
    localparam int unsigned FLASH_AW        = 19;
    localparam int unsigned FLASH_DW        = 16;
    localparam int unsigned TIMER_W         = 8;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RECOVER = 3'd4
    } state_e;

    // A request may only target a word-aligned address in the 1 MiB image.
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr[31:20] == 12'h000);
    endfunction

endpackage : flash_fetch_pkg

`default_nettype wire

// File: rtl/flash_fetch_ctrl_timer.sv
// ============================================================================
// Module      : flash_cycle_timer
// Description : Down-counter shared by the boot reset pulse and the flash
//               access wait. A load sets the number of remaining cycles;
//               last_o flags the final cycle of the loaded interval.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               load_i          - load load_val_i this cycle
//               load_val_i      - cycles remaining after the load edge
//               last_o          - current cycle is the last one
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_cycle_timer
    import flash_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == WIDTH'(1));

endmodule : flash_cycle_timer

`default_nettype wire

// File: rtl/flash_fetch_ctrl.sv
// ============================================================================
// Module      : flash_fetch_ctrl
// Description : Instruction-fetch controller for two 16-bit parallel NOR
//               flash devices (upper/lower halfword). Runs the flash reset
//               pulse after system reset, then serves word-aligned fetches:
//               SETUP (CE# low) -> WAIT (CE#/OE# low, WAIT_CYCLES) ->
//               capture {upper,lower} -> RECOVER -> IDLE.
// Options     : FLASH_FETCH_LAST_HIT_EN - one-entry last-fetch buffer; a
//               repeat of the last fetched address returns in one cycle
//               without touching the flash.
// Ports       : clk, rst                  - clock, async active-high reset
//               fetch_req_i/fetch_addr_i  - core fetch request / byte address
//               fetch_ready_o             - high in IDLE only
//               instr_o/instr_valid_o     - instruction, one-cycle valid
//               fetch_err_o               - one-cycle reject pulse
//               flash_*_o                 - flash strobes and address
//               flash_dq_upper_i/lower_i  - flash read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_fetch_ctrl
    import flash_fetch_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_req_i,
    input  logic [31:0]         fetch_addr_i,
    output logic                fetch_ready_o,
    output logic [31:0]         instr_o,
    output logic                instr_valid_o,
    output logic                fetch_err_o,
    output logic                flash_ce_n_o,
    output logic                flash_oe_n_o,
    output logic                flash_we_n_o,
    output logic                flash_reset_n_o,
    output logic                flash_byte_n_o,
    output logic [FLASH_AW-1:0] flash_a_o,
    input  logic [FLASH_DW-1:0] flash_dq_upper_i,
    input  logic [FLASH_DW-1:0] flash_dq_lower_i
);

    localparam logic [TIMER_W-1:0] c_WAIT_LOAD   = TIMER_W'(WAIT_CYCLES);
    // The first BOOT cycle is spent arming the timer, so it covers one less.
    localparam logic [TIMER_W-1:0] c_RST_LOAD_M1 = TIMER_W'(RST_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  boot_arm_q, boot_arm_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  reset_n_q, reset_n_d;
    logic                  ready_q, ready_d;
    logic [FLASH_AW-1:0]   addr_q, addr_d;
    logic [31:0]           instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  w_tmr_load;
    logic [TIMER_W-1:0]    w_tmr_val;
    logic                  w_tmr_last;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_hit;
    logic [31:0]           w_hit_instr;

    flash_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .last_o     (w_tmr_last)
    );

    assign w_accept  = fetch_req_i && ready_q;
    assign w_capture = (state_q == ST_WAIT) && w_tmr_last;

`ifdef FLASH_FETCH_LAST_HIT_EN
    logic        hit_vld_q;
    logic [17:0] hit_addr_q;
    logic [31:0] hit_instr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_vld_q   <= 1'b0;
            hit_addr_q  <= '0;
            hit_instr_q <= '0;
        end else if (w_capture) begin
            hit_vld_q   <= 1'b1;
            hit_addr_q  <= addr_q[FLASH_AW-1:1];
            hit_instr_q <= {flash_dq_upper_i, flash_dq_lower_i};
        end
    end

    assign w_hit       = hit_vld_q && (fetch_addr_i[19:2] == hit_addr_q);
    assign w_hit_instr = hit_instr_q;
`else
    assign w_hit       = 1'b0;
    assign w_hit_instr = '0;
`endif

    always_comb begin
        state_d    = state_q;
        boot_arm_d = boot_arm_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = c_WAIT_LOAD;
        addr_d     = addr_q;
        instr_d    = instr_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (!boot_arm_q) begin
                    if (RST_CYCLES <= 1) begin
                        state_d = ST_IDLE;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_RST_LOAD_M1;
                        boot_arm_d = 1'b1;
                    end
                end else if (w_tmr_last) begin
                    state_d    = ST_IDLE;
                    boot_arm_d = 1'b0;
                end
            end
            ST_IDLE: begin
                if (w_accept) begin
                    if (!addr_legal(fetch_addr_i)) begin
                        err_d = 1'b1;
                    end else if (w_hit) begin
                        valid_d = 1'b1;
                        instr_d = w_hit_instr;
                    end else begin
                        addr_d  = {fetch_addr_i[19:2], 1'b0};
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = c_WAIT_LOAD;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_tmr_last) begin
                    instr_d = {flash_dq_upper_i, flash_dq_lower_i};
                    valid_d = 1'b1;
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Pins are registered from the next state so they switch cleanly
        // with the state and drop asynchronously with rst.
        ce_n_d    = !((state_d == ST_SETUP) || (state_d == ST_WAIT));
        oe_n_d    = (state_d != ST_WAIT);
        reset_n_d = (state_d != ST_BOOT);
        ready_d   = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_arm_q <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            reset_n_q  <= 1'b0;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_arm_q <= boot_arm_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            reset_n_q  <= reset_n_d;
            ready_q    <= ready_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign fetch_ready_o   = ready_q;
    assign instr_o         = instr_q;
    assign instr_valid_o   = valid_q;
    assign fetch_err_o     = err_q;
    assign flash_ce_n_o    = ce_n_q;
    assign flash_oe_n_o    = oe_n_q;
    assign flash_we_n_o    = 1'b1;
    assign flash_reset_n_o = reset_n_q;
    assign flash_byte_n_o  = 1'b1;
    assign flash_a_o       = addr_q;

endmodule : flash_fetch_ctrl

`default_nettype wire

// File: tb/tb_flash_fetch_ctrl.sv
// ============================================================================
// Module      : tb_flash_fetch_ctrl
// Description : Self-checking bench for flash_fetch_ctrl. Directed steps
//               (boot, single fetch, rejects, back-to-back, repeat fetch,
//               reset during access) followed by random requests, all
//               checked against a transaction-level reference model.
//               Honors FLASH_FETCH_LAST_HIT_EN for the expected behavior.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flash_fetch_ctrl;

    localparam int W = 8;
    localparam int R = 16;
`ifdef FLASH_FETCH_LAST_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] req_addr = '0;
    logic        ready, valid, err, ce_n, oe_n, we_n, reset_n, byte_n;
    logic [31:0] instr;
    logic [18:0] fa;
    logic [15:0] dq_u, dq_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] seed;
    logic        m_hit_vld;
    logic [31:0] m_hit_addr;
    logic [31:0] m_instr;
    logic [18:0] m_a;

    always #5 clk = ~clk;

    flash_fetch_ctrl #(
        .WAIT_CYCLES (W),
        .RST_CYCLES  (R)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req_i      (req),
        .fetch_addr_i     (req_addr),
        .fetch_ready_o    (ready),
        .instr_o          (instr),
        .instr_valid_o    (valid),
        .fetch_err_o      (err),
        .flash_ce_n_o     (ce_n),
        .flash_oe_n_o     (oe_n),
        .flash_we_n_o     (we_n),
        .flash_reset_n_o  (reset_n),
        .flash_byte_n_o   (byte_n),
        .flash_a_o        (fa),
        .flash_dq_upper_i (dq_u),
        .flash_dq_lower_i (dq_l)
    );

    // Flash image model: one known word, the rest derived from the address.
    function automatic logic [31:0] flash_word(input logic [18:0] a, input logic [15:0] s);
        if (a == 19'h00008) return 32'h1234_5678;
        return {a[15:0] ^ s, ~a[15:0] ^ {a[18:16], 13'h0}};
    endfunction

    assign {dq_u, dq_l} = flash_word(fa, seed);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects rst already high; checks reset values, releases rst, checks boot.
    task automatic boot_release();
        int lows, first_hi, vcnt;
        logic strobes_ok, rdy_before, rdy_at;
        chk("rst_ce_n", 32'(ce_n), 32'd1);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_byte_n", 32'(byte_n), 32'd1);
        chk("rst_reset_n", 32'(reset_n), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", 32'(fa), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        m_hit_vld = 1'b0;
        m_instr   = '0;
        m_a       = '0;
        rst = 1'b0;
        #1;
        lows       = (reset_n == 1'b0) ? 1 : 0;
        strobes_ok = ce_n & oe_n;
        first_hi   = -1;
        vcnt       = 0;
        rdy_before = 1'b1;
        rdy_at     = 1'b0;
        for (int j = 1; j <= R + 2; j++) begin
            tick();
            if (!reset_n) lows++;
            else if (first_hi < 0) first_hi = j;
            strobes_ok = strobes_ok & ce_n & oe_n;
            if (valid) vcnt++;
            if (j == R - 1) rdy_before = ready;
            if (j == R) rdy_at = ready;
        end
        chk("boot_reset_n_low_cycles", 32'(lows), 32'(R));
        chk("boot_reset_n_rise_edge", 32'(first_hi), 32'(R));
        chk("boot_ready_before", 32'(rdy_before), 32'd0);
        chk("boot_ready_at", 32'(rdy_at), 32'd1);
        chk("boot_strobes_idle", 32'(strobes_ok), 32'd1);
        chk("boot_no_valid", 32'(vcnt), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        logic        e_err, e_hit, e_full;
        logic [18:0] e_a;
        logic [31:0] e_instr;
        int n, ce_lo, oe_lo, vcnt, vfirst, ecnt, efirst;
        logic ce_rec, rdy_after;

        e_err   = (a[1:0] != 2'b00) || (a[31:20] != 12'h000);
        e_hit   = HIT_EN && !e_err && m_hit_vld && (m_hit_addr[19:2] == a[19:2]);
        e_full  = !e_err && !e_hit;
        e_a     = e_full ? {a[19:2], 1'b0} : m_a;
        e_instr = e_full ? flash_word({a[19:2], 1'b0}, seed) : m_instr;

        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        chk("ready_before_req", 32'(ready), 32'd1);

        req      = 1'b1;
        req_addr = a;
        tick();
        req = 1'b0;

        ce_lo = 0; oe_lo = 0; vcnt = 0; vfirst = -1; ecnt = 0; efirst = -1;
        ce_rec = 1'b0; rdy_after = 1'b0;
        for (int j = 0; j <= W + 3; j++) begin
            if (j > 0) tick();
            if (!ce_n) ce_lo++;
            if (!oe_n) oe_lo++;
            if (valid) begin vcnt++; if (vfirst < 0) vfirst = j; end
            if (err) begin ecnt++; if (efirst < 0) efirst = j; end
            if (j == W + 1) ce_rec = ce_n;
            if (j == W + 2) rdy_after = ready;
        end

        chk($sformatf("err_count[%h]", a), 32'(ecnt), e_err ? 32'd1 : 32'd0);
        chk($sformatf("err_edge[%h]", a), 32'(efirst), e_err ? 32'd0 : 32'hFFFF_FFFF);
        chk($sformatf("valid_count[%h]", a), 32'(vcnt), e_err ? 32'd0 : 32'd1);
        chk($sformatf("valid_edge[%h]", a), 32'(vfirst),
            e_full ? 32'(W + 1) : (e_hit ? 32'd0 : 32'hFFFF_FFFF));
        chk($sformatf("ce_low_cycles[%h]", a), 32'(ce_lo), e_full ? 32'(W + 1) : 32'd0);
        chk($sformatf("oe_low_cycles[%h]", a), 32'(oe_lo), e_full ? 32'(W) : 32'd0);
        chk($sformatf("instr[%h]", a), instr, e_instr);
        chk($sformatf("flash_a[%h]", a), 32'(fa), 32'(e_a));
        if (e_full) begin
            chk($sformatf("recover_ce_n[%h]", a), 32'(ce_rec), 32'd1);
            chk($sformatf("ready_after[%h]", a), 32'(rdy_after), 32'd1);
            m_hit_vld  = 1'b1;
            m_hit_addr = a;
            m_a        = e_a;
        end
        m_instr = e_instr;
    endtask

    initial begin
        int n;
        logic ce_rec;
        logic [31:0] a;

        seed = 16'($urandom);
        repeat (3) tick();
        boot_release();

        // Single fetch with the known image word
        do_fetch(32'h0000_0010);
        // Rejected requests
        do_fetch(32'h0000_0006);
        do_fetch(32'h0010_0000);

        // Back-to-back with request held high
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        req = 1'b1;
        req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        n = 0;
        ce_rec = 1'b0;
        while (!ready && n < 40) begin
            tick();
            n++;
            if (n == W + 1) ce_rec = ce_n;
        end
        chk("b2b_accept_spacing", 32'(n + 1), 32'(W + 3));
        chk("b2b_recover_ce_n", 32'(ce_rec), 32'd1);
        tick();
        req = 1'b0;
        n = 0;
        while (!valid && n < 40) begin tick(); n++; end
        chk("b2b_second_instr", instr, flash_word(19'h00002, seed));
        m_hit_vld  = 1'b1;
        m_hit_addr = 32'h4;
        m_instr    = flash_word(19'h00002, seed);
        m_a        = 19'h00002;

        // Repeat fetch of the same address
        do_fetch(32'h0000_0008);
        do_fetch(32'h0000_0008);

        // Reset in the middle of WAIT
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        req = 1'b1;
        req_addr = 32'h0000_0020;
        tick();
        req = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ce_n", 32'(ce_n), 32'd1);
        chk("midrst_oe_n", 32'(oe_n), 32'd1);
        chk("midrst_reset_n", 32'(reset_n), 32'd0);
        n = 0;
        for (int j = 0; j < W + 3; j++) begin
            tick();
            if (valid) n++;
        end
        chk("midrst_no_valid", 32'(n), 32'd0);
        boot_release();

        // Random requests
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0, 1: a = {12'h000, 20'($urandom)} | 32'h1 << $urandom_range(0, 1);
                2:    a = {12'($urandom_range(1, 4095)), 18'($urandom), 2'b00};
                3, 4: a = m_hit_addr;
                default: a = {12'h000, 18'($urandom), 2'b00};
            endcase
            repeat ($urandom_range(0, 3)) tick();
            do_fetch(a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flash_fetch_ctrl

`default_nettype wire
